h_eqlz_seq: RTL

- Sequenced successor to the per-symbol equaliser-coefficient select mux.
- Walks all NUM_SC subcarriers of one NB-IoT RB symbol and emits one channel coefficient per subcarrier on a valid/ready stream.
- Sources per subcarrier: latched NRS pilot estimates at the two pilot positions given by v_shift; interpolated/divided results, pulled from an upstream valid/ready stream, everywhere else.
- Sits between the interpolation divider and the equaliser.

---
 rtl/h_eqlz_seq_if.sv | 25 ++
 rtl/h_eqlz_seq.sv | 138 +++++++++++++
 2 files changed

// File: rtl/h_eqlz_seq_if.sv
// Coefficient streams around h_eqlz_seq: interpolated words in, per-subcarrier words out.
// master = the sequencer side, slave = the divider/equaliser side.
interface h_eqlz_seq_if #(
  parameter int WIDTH = 17,
  parameter int SC_W  = 4
);
  logic [WIDTH-1:0] interp_data;
  logic             interp_valid;
  logic             interp_ready;
  logic [WIDTH-1:0] h_eqlz;
  logic [SC_W-1:0]  h_sc_idx;
  logic             h_valid;
  logic             h_ready;
  logic             h_last;

  modport master (
    input  interp_data, interp_valid, h_ready,
    output interp_ready, h_eqlz, h_sc_idx, h_valid, h_last
  );

  modport slave (
    output interp_data, interp_valid, h_ready,
    input  interp_ready, h_eqlz, h_sc_idx, h_valid, h_last
  );
endinterface

// File: rtl/h_eqlz_seq.sv
// Walks the subcarriers of one RB symbol, emitting pilot or interpolated coefficient per index.
// First word two cycles after start; one-deep output reg, h_ready low stalls loads and interp_ready.
// Optional H_EQLZ_SEQ_ERR_EN adds err_sticky (restart while running, or v_shift > 5).
module h_eqlz_seq #(
  parameter int WIDTH  = 17,
  parameter int NUM_SC = 12,
  parameter int SC_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       v_shift,
  input  logic [WIDTH-1:0] pilot_a,
  input  logic [WIDTH-1:0] pilot_b,
  h_eqlz_seq_if.master     bus,
  output logic             busy
`ifdef H_EQLZ_SEQ_ERR_EN
  ,
  output logic             err_sticky
`endif
);

  // One spare bit so the counter can sit at NUM_SC even when NUM_SC == 2^SC_W.
  localparam int CW = SC_W + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    sc_q, sc_d;
  logic [2:0]       vs_q, vs_d;
  logic [WIDTH-1:0] pa_q, pa_d;
  logic [WIDTH-1:0] pb_q, pb_d;
  logic [WIDTH-1:0] h_dat_q, h_dat_d;
  logic [SC_W-1:0]  h_idx_q, h_idx_d;
  logic             h_vld_q, h_vld_d;
  logic             h_last_q, h_last_d;

  logic [CW-1:0]    p0, p1;
  logic             is_pilot, is_p0, more, load_ok, load, accept;

  always_comb begin
    p0       = CW'(vs_q);
    p1       = CW'(vs_q) + CW'(6);
    is_p0    = (sc_q == p0);
    is_pilot = is_p0 || (sc_q == p1);
    more     = (sc_q < CW'(NUM_SC));
    load_ok  = !h_vld_q || bus.h_ready;
    accept   = h_vld_q && bus.h_ready;
    load     = (state_q == RUN) && more && load_ok && (is_pilot || bus.interp_valid);
  end

  assign bus.interp_ready = (state_q == RUN) && more && load_ok && !is_pilot;

  always_comb begin
    state_d  = state_q;
    sc_d     = sc_q;
    vs_d     = vs_q;
    pa_d     = pa_q;
    pb_d     = pb_q;
    h_dat_d  = h_dat_q;
    h_idx_d  = h_idx_q;
    h_vld_d  = h_vld_q;
    h_last_d = h_last_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          vs_d    = (v_shift > 3'd5) ? (v_shift - 3'd6) : v_shift;
          pa_d    = pilot_a;
          pb_d    = pilot_b;
          sc_d    = '0;
        end
      end
      RUN: begin
        if (accept && h_last_q) begin
          h_vld_d  = 1'b0;
          h_last_d = 1'b0;
          state_d  = IDLE;
        end else if (load) begin
          h_dat_d  = is_pilot ? (is_p0 ? pa_q : pb_q) : bus.interp_data;
          h_idx_d  = sc_q[SC_W-1:0];
          h_last_d = (sc_q == CW'(NUM_SC - 1));
          h_vld_d  = 1'b1;
          sc_d     = sc_q + CW'(1);
        end else if (accept) begin
          h_vld_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sc_q     <= '0;
      vs_q     <= '0;
      pa_q     <= '0;
      pb_q     <= '0;
      h_dat_q  <= '0;
      h_idx_q  <= '0;
      h_vld_q  <= 1'b0;
      h_last_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sc_q     <= sc_d;
      vs_q     <= vs_d;
      pa_q     <= pa_d;
      pb_q     <= pb_d;
      h_dat_q  <= h_dat_d;
      h_idx_q  <= h_idx_d;
      h_vld_q  <= h_vld_d;
      h_last_q <= h_last_d;
    end
  end

  assign bus.h_eqlz   = h_dat_q;
  assign bus.h_sc_idx = h_idx_q;
  assign bus.h_valid  = h_vld_q;
  assign bus.h_last   = h_last_q;
  assign busy         = (state_q == RUN);

`ifdef H_EQLZ_SEQ_ERR_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (start && ((state_q == RUN) || (v_shift > 3'd5))) begin
      err_q <= 1'b1;
    end
  end

  assign err_sticky = err_q;
`endif

endmodule
